// File: rtl/nnl_reduce9_pkg.sv
// Shared fixed-point definitions for the nnl_* layers: widths, FSM states
// and the 16-bit saturating narrow used at every layer output.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int ACC_W  = 36;
    localparam int N      = 9;
    localparam int IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        BIAS = 3'd3,
        DONE = 3'd4
    } state_t;

    // Clamp a (ACC_W+1)-bit signed value to the signed 16-bit range.
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W:0] v);
        localparam logic signed [ACC_W:0] SMAX = 37'sd32767;
        localparam logic signed [ACC_W:0] SMIN = -37'sd32768;
        if (v > SMAX)
            return 16'sh7fff;
        else if (v < SMIN)
            return 16'sh8000;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/nnl_reduce9_mac.sv
// Building blocks for the reduction layer: a clear-on-disable capture
// register and a registered signed multiply-accumulate.
import nn_pkg::*;

// Capture register; synchronous clr wins over load enable.
module nn_reg #(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;

    // Hold, clear or load the stored word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q_q <= '0;
        else if (clr)
            q_q <= '0;
        else if (en)
            q_q <= d;
    end

    assign q = q_q;
endmodule

// acc += a*b when en; clr has priority and zeroes the accumulator.
module mac_unit (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_out
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d;

    // Full-precision product, sign-extended into the wide accumulator.
    always_comb begin
        prod  = a * b;
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_out = acc_q;
endmodule

// File: rtl/nnl_reduce9.sv
// Nine-input neuron: res = sat16(((sum x_i*w_i) >>> FRAC) + b), one shared
// MAC over nine cycles, level-enable / start / done handshake.
import nn_pkg::*;

module nnl_reduce9 (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     red_en,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    input  logic signed [DATA_W-1:0] x5,
    input  logic signed [DATA_W-1:0] x6,
    input  logic signed [DATA_W-1:0] x7,
    input  logic signed [DATA_W-1:0] x8,
    input  logic signed [DATA_W-1:0] x9,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    input  logic signed [DATA_W-1:0] w4,
    input  logic signed [DATA_W-1:0] w5,
    input  logic signed [DATA_W-1:0] w6,
    input  logic signed [DATA_W-1:0] w7,
    input  logic signed [DATA_W-1:0] w8,
    input  logic signed [DATA_W-1:0] w9,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] res,
    output logic                     start,
    output logic                     done
);
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0][DATA_W-1:0] x_in, w_in, xcap, wcap;
    logic [DATA_W-1:0]       bcap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic [ACC_W:0]          tmp;
    logic signed [DATA_W-1:0] res_q;
    logic                    cap_en, mac_clr, mac_en;

    assign x_in = {x9, x8, x7, x6, x5, x4, x3, x2, x1};
    assign w_in = {w9, w8, w7, w6, w5, w4, w3, w2, w1};

    assign cap_en  = (state_q == LOAD);
    assign mac_clr = !red_en || (state_q == LOAD);
    assign mac_en  = (state_q == MAC);

    // Operand capture; dropping red_en wipes the captured operands.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cap
            nn_reg #(.W(DATA_W)) u_xcap (
                .clk(clk), .rst(rst), .clr(!red_en), .en(cap_en),
                .d(x_in[gi]), .q(xcap[gi])
            );
            nn_reg #(.W(DATA_W)) u_wcap (
                .clk(clk), .rst(rst), .clr(!red_en), .en(cap_en),
                .d(w_in[gi]), .q(wcap[gi])
            );
        end
    endgenerate

    nn_reg #(.W(DATA_W)) u_bcap (
        .clk(clk), .rst(rst), .clr(!red_en), .en(cap_en),
        .d(b), .q(bcap)
    );

    mac_unit u_mac (
        .clk(clk), .rst(rst), .clr(mac_clr), .en(mac_en),
        .a($signed(xcap[idx_q])), .b($signed(wcap[idx_q])),
        .acc_out(acc)
    );

    // Next state and operand index; red_en low always returns to IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        case (state_q)
            IDLE: if (red_en) state_d = LOAD;
            LOAD: state_d = MAC;
            MAC: begin
                if (idx_q == IDX_W'(N-1))
                    state_d = BIAS;
                else
                    idx_d = idx_q + 1'b1;
            end
            BIAS: state_d = DONE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!red_en) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Scale back to Q7.8 (arithmetic shift floors), add bias, widened by one bit.
    always_comb begin
        acc_sh = acc >>> FRAC;
        tmp    = {acc_sh[ACC_W-1], acc_sh}
               + {{(ACC_W+1-DATA_W){bcap[DATA_W-1]}}, bcap};
    end

    // Result register; written only by a BIAS cycle that is not being aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            res_q <= '0;
        else if (state_q == BIAS && red_en)
            res_q <= sat16($signed(tmp));
    end

    assign res   = res_q;
    assign start = (state_q == LOAD);
    assign done  = (state_q == DONE);
endmodule

// File: tb/tb_nnl_reduce9.sv
// Bench for nnl_reduce9: directed table, abort/reset/capture sequences and
// random vectors against an integer reference model.
module tb_nnl_reduce9;

    typedef struct packed {
        logic [8:0][15:0] x;
        logic [8:0][15:0] w;
        logic [15:0]      b;
        logic [15:0]      exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             red_en = 1'b0;
    logic [8:0][15:0] xv = '0;
    logic [8:0][15:0] wv = '0;
    logic [15:0]      bv = '0;
    logic [15:0]      res;
    logic             start, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nnl_reduce9 dut (
        .clk(clk), .rst(rst), .red_en(red_en),
        .x1(xv[0]), .x2(xv[1]), .x3(xv[2]), .x4(xv[3]), .x5(xv[4]),
        .x6(xv[5]), .x7(xv[6]), .x8(xv[7]), .x9(xv[8]),
        .w1(wv[0]), .w2(wv[1]), .w3(wv[2]), .w4(wv[3]), .w5(wv[4]),
        .w6(wv[5]), .w7(wv[6]), .w8(wv[7]), .w9(wv[8]),
        .b(bv), .res(res), .start(start), .done(done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: exact integer dot product, floor-divide by 256, add bias, clamp.
    function automatic logic [15:0] model(input vec_t v);
        longint s = 0;
        for (int i = 0; i < 9; i++)
            s += longint'($signed(v.x[i])) * longint'($signed(v.w[i]));
        s = s >>> 8;
        s += longint'($signed(v.b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Full run from IDLE; called at a negedge with red_en low.
    task automatic do_run(input vec_t v, input string nm, input bit zero_at3);
        xv = v.x; wv = v.w; bv = v.b;
        red_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); @(negedge clk);
            chk({nm, "_start"}, {31'd0, start}, {31'd0, c == 1});
            chk({nm, "_done"}, {31'd0, done}, {31'd0, c == 12});
            if (c == 3 && zero_at3) xv = '0;
        end
        chk({nm, "_res"}, {16'd0, res}, {16'd0, v.exp});
        red_en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk({nm, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({nm, "_res_hold"}, {16'd0, res}, {16'd0, v.exp});
    endtask

    vec_t tbl[5];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0].x = {9{16'd256}};  tbl[0].w = {9{16'd256}};  tbl[0].b = 16'd0;
        tbl[0].exp = 16'd2304;
        tbl[1].x = '0; tbl[1].w = '0; tbl[1].x[0] = 16'hff00; tbl[1].w[0] = 16'd256;
        tbl[1].b = 16'd128; tbl[1].exp = 16'hff80;
        tbl[2].x = '0; tbl[2].w = '0; tbl[2].x[0] = 16'hffff; tbl[2].w[0] = 16'd1;
        tbl[2].b = 16'd0; tbl[2].exp = 16'hffff;
        tbl[3].x = {9{16'h7fff}}; tbl[3].w = {9{16'h7fff}}; tbl[3].b = 16'h7fff;
        tbl[3].exp = 16'h7fff;
        tbl[4].x = {9{16'h8000}}; tbl[4].w = {9{16'h7fff}}; tbl[4].b = 16'd0;
        tbl[4].exp = 16'h8000;

        // Reset state.
        @(negedge clk); @(negedge clk);
        chk("rst_res", {16'd0, res}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) do_run(tbl[i], $sformatf("tbl%0d", i), 1'b0);

        // Completed run, then abort during cycle 6.
        do_run(tbl[0], "pre_abort", 1'b0);
        xv = '0; wv = '0; bv = 16'd5;
        red_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_done", {31'd0, done}, 32'd0);
        end
        red_en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_done7", {31'd0, done}, 32'd0);
        chk("abort_start7", {31'd0, start}, 32'd0);
        chk("abort_res", {16'd0, res}, 32'd2304);
        do_run(tbl[1], "post_abort", 1'b0);

        // Asynchronous reset during cycle 8.
        xv = tbl[3].x; wv = tbl[3].w; bv = tbl[3].b;
        red_en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("arst_res", {16'd0, res}, 32'd0);
        chk("arst_start", {31'd0, start}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        red_en = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("arst_hold_res", {16'd0, res}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        do_run(tbl[0], "post_rst", 1'b0);

        // Inputs zeroed mid-run must not affect the captured operands.
        do_run(tbl[0], "capture", 1'b1);

        // Random vectors: full-range and moderate magnitudes.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 9; i++) begin
                if (r < 8) begin
                    v.x[i] = 16'($urandom);
                    v.w[i] = 16'($urandom);
                end else begin
                    v.x[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
                    v.w[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                end
            end
            v.b   = 16'($urandom_range(0, 4095)) - 16'd2048;
            v.exp = model(v);
            do_run(v, $sformatf("rnd%0d", r), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
